// File: rtl/stream_arb_mux.sv
// stream_arb_mux: N-input packet-aware stream arbiter with a single-register
// output stage. Arbitration is either round-robin (MODE=0) or fixed priority
// with the lowest index winning (MODE=1). Once a multi-beat packet starts, the
// grant stays locked on its channel until that packet's last beat is accepted,
// so packets from different channels are never interleaved on the output.
//
// Handshake: a beat moves across any valid/ready pair on the clk edge where
// both are high. Valid never depends on ready on the output side; in_ready
// depends on out_valid/out_ready, in_valid (grant selection) and resetn.
module stream_arb_mux #(
    parameter int WIDTH    = 64,
    parameter int CHANNELS = 4,
    parameter int MODE     = 0,
    localparam int CW      = (CHANNELS == 1) ? 1 : $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    output logic                      out_last,
    output logic [CW-1:0]             out_chan,
    input  logic                      out_ready,
    output logic                      busy
);

    // FSM state: IDLE arbitrates freely, LOCK holds the grant on one channel
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;

    // Channel that owns the grant while locked, and the round-robin pointer
    logic [CW-1:0]   lock_chan;
    logic [CW-1:0]   ptr;
    logic [CW-1:0]   ptr_inc;

    // Arbitration results
    logic            lo_found;
    logic [CW-1:0]   lo_chan;
    logic            hi_found;
    logic [CW-1:0]   hi_chan;
    logic [CW-1:0]   rr_chan;
    logic [CW-1:0]   pick_chan;
    logic            any_valid;

    // Grant as seen by the datapath
    logic            grant_en;
    logic [CW-1:0]   grant_chan;

    // Granted channel's beat
    logic [WIDTH-1:0] sel_data;
    logic             sel_valid;
    logic             sel_last;

    // Handshake helpers
    logic            can_load;
    logic            accept;

    // The output register can take a new beat when empty or being drained
    assign can_load  = !out_valid || out_ready;
    assign any_valid = |in_valid;

    // Priority search: lowest valid index overall, and lowest valid index at
    // or above ptr. Round-robin prefers the latter, which is the same as an
    // ascending search from ptr that wraps modulo CHANNELS.
    always_comb begin
        lo_found = 1'b0;
        lo_chan  = '0;
        hi_found = 1'b0;
        hi_chan  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (in_valid[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_chan  = CW'(i);
            end
            if (in_valid[i] && (CW'(i) >= ptr) && !hi_found) begin
                hi_found = 1'b1;
                hi_chan  = CW'(i);
            end
        end
    end

    // Policy selection; a single channel always resolves to index 0
    always_comb begin
        rr_chan = hi_found ? hi_chan : lo_chan;
        if (CHANNELS == 1) begin
            pick_chan = '0;
        end else if (MODE == 0) begin
            pick_chan = rr_chan;
        end else begin
            pick_chan = lo_chan;
        end
    end

    // Next-state logic: lock on a non-last beat, unlock on the last beat
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept && !sel_last) begin
                    state_next = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (accept && sel_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: which channel holds the grant, and whether it is locked
    always_comb begin
        busy       = 1'b0;
        grant_en   = 1'b0;
        grant_chan = '0;
        case (state)
            ST_IDLE: begin
                grant_en   = any_valid;
                grant_chan = pick_chan;
            end
            ST_LOCK: begin
                busy       = 1'b1;
                grant_en   = 1'b1;
                grant_chan = lock_chan;
            end
            default: begin
                grant_en   = 1'b0;
                grant_chan = '0;
            end
        endcase
    end

    // Mux the granted channel's beat and drive the one-hot ready
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        in_ready  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (CW'(i) == grant_chan) begin
                sel_data    = in_data[i*WIDTH +: WIDTH];
                sel_valid   = in_valid[i];
                sel_last    = in_last[i];
                in_ready[i] = resetn && grant_en && can_load;
            end
        end
    end

    // A beat is taken only from the granted channel
    assign accept = sel_valid && resetn && grant_en && can_load;

    // Pointer advances to the channel after the one that just finished a packet
    assign ptr_inc = (grant_chan == CW'(CHANNELS - 1)) ? '0 : grant_chan + CW'(1);

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the owning channel when a multi-beat packet starts
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_chan <= '0;
        end else if (state == ST_IDLE && accept && !sel_last) begin
            lock_chan <= grant_chan;
        end
    end

    // Round-robin pointer moves only at packet boundaries
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr <= '0;
        end else if (MODE == 0 && accept && sel_last) begin
            ptr <= ptr_inc;
        end
    end

    // Output register: load on accept, drain when consumed with nothing new
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_last  <= sel_last;
            out_data  <= sel_data;
            out_chan  <= grant_chan;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed bench for stream_arb_mux: round-robin and fixed-priority 4-channel
// instances plus a single-channel 8-bit instance streaming 256 beats.
module tb_stream_arb_mux;

    localparam int W = 64;
    localparam int N = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    // Round-robin instance
    logic [N*W-1:0] a_in_data;
    logic [N-1:0]   a_in_valid, a_in_last, a_in_ready;
    logic [W-1:0]   a_out_data;
    logic           a_out_valid, a_out_last, a_out_ready, a_busy;
    logic [1:0]     a_out_chan;

    // Fixed-priority instance
    logic [N*W-1:0] b_in_data;
    logic [N-1:0]   b_in_valid, b_in_last, b_in_ready;
    logic [W-1:0]   b_out_data;
    logic           b_out_valid, b_out_last, b_out_ready, b_busy;
    logic [1:0]     b_out_chan;

    // Single-channel instance
    logic [7:0]     c_in_data;
    logic [0:0]     c_in_valid, c_in_last, c_in_ready;
    logic [7:0]     c_out_data;
    logic           c_out_valid, c_out_last, c_out_ready, c_busy;
    logic [0:0]     c_out_chan;

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] exp_q[$];

    stream_arb_mux #(.WIDTH(W), .CHANNELS(N), .MODE(0)) u_rr (
        .clk(clk), .resetn(resetn),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_last(a_in_last), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_last(a_out_last),
        .out_chan(a_out_chan), .out_ready(a_out_ready), .busy(a_busy)
    );

    stream_arb_mux #(.WIDTH(W), .CHANNELS(N), .MODE(1)) u_fp (
        .clk(clk), .resetn(resetn),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_last(b_in_last), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_last(b_out_last),
        .out_chan(b_out_chan), .out_ready(b_out_ready), .busy(b_busy)
    );

    stream_arb_mux #(.WIDTH(8), .CHANNELS(1), .MODE(1)) u_one (
        .clk(clk), .resetn(resetn),
        .in_data(c_in_data), .in_valid(c_in_valid), .in_last(c_in_last), .in_ready(c_in_ready),
        .out_data(c_out_data), .out_valid(c_out_valid), .out_last(c_out_last),
        .out_chan(c_out_chan), .out_ready(c_out_ready), .busy(c_busy)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_a(input int ch, input logic [W-1:0] val);
        for (int i = 0; i < N; i++) if (i == ch) a_in_data[i*W +: W] = val;
    endtask

    task automatic set_b(input int ch, input logic [W-1:0] val);
        for (int i = 0; i < N; i++) if (i == ch) b_in_data[i*W +: W] = val;
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        int sent, recv, cycles;
        logic [8:0] exp_v;

        a_in_data = '0; a_in_valid = '0; a_in_last = '0; a_out_ready = 1'b1;
        b_in_data = '0; b_in_valid = '0; b_in_last = '0; b_out_ready = 1'b1;
        c_in_data = '0; c_in_valid = '0; c_in_last = '0; c_out_ready = 1'b0;

        // Reset: ready stays low even with all valids high
        resetn = 1'b0;
        a_in_valid = '1;
        b_in_valid = '1;
        #1;
        chk("rst_a_ready", a_in_ready, 0);
        chk("rst_b_ready", b_in_ready, 0);
        tick();
        tick();
        chk("rst_a_valid", a_out_valid, 0);
        chk("rst_a_data", a_out_data, 0);
        chk("rst_a_chan", a_out_chan, 0);
        chk("rst_a_last", a_out_last, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_b_valid", b_out_valid, 0);
        chk("rst_c_valid", c_out_valid, 0);
        a_in_valid = '0;
        b_in_valid = '0;
        resetn = 1'b1;

        // Round-robin, single-beat packets on all channels
        for (int i = 0; i < N; i++) set_a(i, 64'h100 + 64'(i));
        a_in_last = '1;
        a_in_valid = '1;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("rr_ready", a_in_ready, 64'd1 << (k % 4));
            tick();
            chk("rr_valid", a_out_valid, 1);
            chk("rr_chan", a_out_chan, 64'(k % 4));
            chk("rr_data", a_out_data, 64'h100 + 64'(k % 4));
            chk("rr_last", a_out_last, 1);
        end
        a_in_valid = '0;
        tick();
        chk("rr_drain", a_out_valid, 0);

        // Fixed priority: channel 0 wins until it drops valid
        for (int i = 0; i < N; i++) set_b(i, 64'h200 + 64'(i));
        b_in_last = '1;
        b_in_valid = '1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("fp_ready", b_in_ready, 4'b0001);
            tick();
            chk("fp_chan", b_out_chan, 0);
            chk("fp_data", b_out_data, 64'h200);
        end
        b_in_valid = 4'b1110;
        #1;
        chk("fp_ready1", b_in_ready, 4'b0010);
        tick();
        chk("fp_chan1", b_out_chan, 1);
        chk("fp_data1", b_out_data, 64'h201);
        b_in_valid = '0;
        tick();
        chk("fp_drain", b_out_valid, 0);

        // Move the round-robin pointer to 2 with one beat on channel 1
        set_a(1, 64'h1A0);
        a_in_valid = 4'b0010;
        a_in_last = 4'b0010;
        #1;
        chk("lk_pre_ready", a_in_ready, 4'b0010);
        tick();
        chk("lk_pre_chan", a_out_chan, 1);
        chk("lk_pre_busy", a_busy, 0);

        // 3-beat packet on channel 2 with channel 0 valid throughout
        set_a(2, 64'h2A1);
        set_a(0, 64'h0A0);
        a_in_valid = 4'b0101;
        a_in_last = 4'b0001;
        #1;
        chk("lk_b1_ready", a_in_ready, 4'b0100);
        tick();
        chk("lk_b1_chan", a_out_chan, 2);
        chk("lk_b1_data", a_out_data, 64'h2A1);
        chk("lk_b1_last", a_out_last, 0);
        chk("lk_b1_busy", a_busy, 1);
        set_a(2, 64'h2A2);
        #1;
        chk("lk_b2_ready", a_in_ready, 4'b0100);
        tick();
        chk("lk_b2_chan", a_out_chan, 2);
        chk("lk_b2_data", a_out_data, 64'h2A2);
        chk("lk_b2_busy", a_busy, 1);
        // Locked channel idles: channel 0 still shut out
        a_in_valid = 4'b0001;
        #1;
        chk("lk_gap_ready", a_in_ready, 4'b0100);
        tick();
        chk("lk_gap_valid", a_out_valid, 0);
        chk("lk_gap_busy", a_busy, 1);
        set_a(2, 64'h2A3);
        a_in_valid = 4'b0101;
        a_in_last = 4'b0101;
        #1;
        chk("lk_b3_ready", a_in_ready, 4'b0100);
        tick();
        chk("lk_b3_chan", a_out_chan, 2);
        chk("lk_b3_data", a_out_data, 64'h2A3);
        chk("lk_b3_last", a_out_last, 1);
        chk("lk_b3_busy", a_busy, 0);
        a_in_valid = 4'b0001;
        #1;
        chk("lk_post_ready", a_in_ready, 4'b0001);
        tick();
        chk("lk_post_chan", a_out_chan, 0);
        chk("lk_post_data", a_out_data, 64'h0A0);
        a_in_valid = '0;
        tick();

        // Backpressure: hold out_ready low for 5 edges
        a_out_ready = 1'b0;
        set_a(0, 64'hDEADBEEF);
        a_in_valid = 4'b0001;
        a_in_last = 4'b0001;
        #1;
        tick();
        chk("bp_first_valid", a_out_valid, 1);
        chk("bp_first_data", a_out_data, 64'hDEADBEEF);
        set_a(0, 64'h12345678);
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_ready", a_in_ready, 0);
            tick();
            chk("bp_hold_valid", a_out_valid, 1);
            chk("bp_hold_data", a_out_data, 64'hDEADBEEF);
        end
        a_out_ready = 1'b1;
        #1;
        chk("bp_rel_ready", a_in_ready, 4'b0001);
        tick();
        chk("bp_next_valid", a_out_valid, 1);
        chk("bp_next_data", a_out_data, 64'h12345678);
        a_in_valid = '0;
        tick();
        chk("bp_drain", a_out_valid, 0);

        // Reset in the middle of a 4-beat packet on channel 3
        set_a(3, 64'h3B1);
        a_in_valid = 4'b1000;
        a_in_last = 4'b0000;
        #1;
        chk("mr_b1_ready", a_in_ready, 4'b1000);
        tick();
        chk("mr_b1_chan", a_out_chan, 3);
        chk("mr_b1_busy", a_busy, 1);
        set_a(3, 64'h3B2);
        tick();
        chk("mr_b2_data", a_out_data, 64'h3B2);
        chk("mr_b2_busy", a_busy, 1);
        resetn = 1'b0;
        set_a(3, 64'h3B3);
        #1;
        chk("mr_rst_ready", a_in_ready, 0);
        tick();
        chk("mr_rst_valid", a_out_valid, 0);
        chk("mr_rst_busy", a_busy, 0);
        chk("mr_rst_data", a_out_data, 0);
        resetn = 1'b1;
        set_a(1, 64'h1C0);
        a_in_valid = 4'b0010;
        a_in_last = 4'b0010;
        #1;
        chk("mr_c1_ready", a_in_ready, 4'b0010);
        tick();
        chk("mr_c1_chan", a_out_chan, 1);
        chk("mr_c1_data", a_out_data, 64'h1C0);
        chk("mr_c1_busy", a_busy, 0);
        a_in_valid = '0;
        tick();

        // Single channel: 256 beats, random out_ready, scoreboard in order
        sent = 0;
        recv = 0;
        cycles = 0;
        while (recv < 256 && cycles < 3000) begin
            c_out_ready = 1'($urandom_range(0, 1));
            c_in_data = sent[7:0];
            c_in_last = 1'((sent % 16) == 15);
            c_in_valid = 1'(sent < 256);
            #1;
            if (c_out_valid && c_out_ready) begin
                chk("one_q_nonempty", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_v = exp_q.pop_front();
                    chk("one_beat", {c_out_last, c_out_data}, exp_v);
                end
                chk("one_chan", c_out_chan, 0);
                recv++;
            end
            if (c_in_valid[0] && c_in_ready[0]) begin
                exp_q.push_back({c_in_last[0], c_in_data});
                sent++;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        chk("one_count", 64'(recv), 256);
        chk("one_q_empty", 64'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
